// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline sequencer for the 5-stage RV32I core.
//
// Watches the ID and EX stages and produces every stall/flush control for
// pc_reg, if_id and id_ex:
//   * load-use hazard between decode sources and an EX-stage load -> 1 bubble
//   * taken branch/JAL from EX -> PC redirect, flush IF/ID and ID/EX, then
//     keep IF/ID flushed for FETCH_LAT more cycles (instruction ROM latency)
//   * external freeze (bus/debug) via hold_req_i / hold_ack_o
// Also counts the cycles in which the PC was held (saturating).
//
// Handshake: hold_req_i is a level held by the requester until it is done.
// hold_ack_o is registered and is high exactly while the pipeline is frozen;
// the requester may rely on a frozen pipeline only while hold_ack_o=1, and
// drops hold_req_i to release it. hold_ack_o falls at the edge that leaves
// the frozen state.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rs1/rs2_addr_i    decode-stage source registers (0 when unused)
//   ex_rd_addr_i      EX-stage destination, ex_reg_wen_i / ex_is_load_i flags
//   jump_en_i/addr_i  EX-stage taken branch/JAL and its target
//   hold_req_i        external freeze request
//   pc_load_o/addr_o  PC redirect strobe and target (addr is 0 when no load)
//   *_stall_o/*_flush_o  pipeline register controls
//   hold_ack_o        pipeline frozen
//   stall_cnt_o       cycles with pc_stall_o=1, saturating
module pipe_ctrl #(
  parameter int FETCH_LAT = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_addr_i,
  input  logic [4:0]       rs2_addr_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_reg_wen_i,
  input  logic             ex_is_load_i,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_req_i,
  output logic             pc_load_o,
  output logic [31:0]      pc_load_addr_o,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             hold_ack_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [2:0]       FLUSH_INIT = 3'(FETCH_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic             hold_ack_q, hold_ack_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;

  // x0 is hardwired to zero, so a load targeting it can never hazard.
  assign load_use = ex_is_load_i & ex_reg_wen_i & (ex_rd_addr_i != 5'd0) &
                    ((ex_rd_addr_i == rs1_addr_i) | (ex_rd_addr_i == rs2_addr_i));

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    pc_load_o     = 1'b0;
    pc_stall_o    = 1'b0;
    if_id_stall_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_stall_o = 1'b0;
    id_ex_flush_o = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (jump_en_i) begin
          pc_load_o     = 1'b1;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          if (FLUSH_INIT != 3'd0) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end
        end else if (hold_req_i) begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_stall_o = 1'b1;
          state_d       = ST_HOLD;
        end else if (load_use) begin
          // The bubble in ID/EX removes the load from EX next cycle, so the
          // condition clears by itself after exactly one cycle.
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end
      end

      ST_FLUSH: begin
        // Fetch results still in flight belong to the old path; discard them.
        // Load-use is not checked here and a pending hold waits for RUN.
        if_id_flush_o = 1'b1;
        if (jump_en_i) begin
          pc_load_o     = 1'b1;
          id_ex_flush_o = 1'b1;
          flush_cnt_d   = FLUSH_INIT;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
          if (flush_cnt_q <= 3'd1) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_HOLD: begin
        // EX is frozen, so jump_en_i and load-use cannot change here.
        pc_stall_o    = 1'b1;
        if_id_stall_o = 1'b1;
        id_ex_stall_o = 1'b1;
        if (!hold_req_i) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = 3'd0;
      end
    endcase
  end

  assign hold_ack_d = (state_d == ST_HOLD);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
      hold_ack_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      hold_ack_q  <= hold_ack_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_load_addr_o = pc_load_o ? jump_addr_i : 32'd0;
  assign hold_ack_o     = hold_ack_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl. Two instances share the stimulus:
//   dut_a: FETCH_LAT=1, CNT_W=32   dut_b: FETCH_LAT=3, CNT_W=4
// Each directed vector carries hand-computed outputs; the driver pushes them
// into exp_q and the monitor compares them on the falling edge.
module tb_pipe_ctrl;

  // Expected entry: {sel, ctl[6:0], addr[31:0], cnt[31:0]}
  // ctl = {pc_load, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, hold_ack}
  localparam int W = 72;

  logic clk;
  logic rst_n;
  logic [4:0]  rs1_addr, rs2_addr, ex_rd_addr;
  logic        ex_reg_wen, ex_is_load, jump_en, hold_req;
  logic [31:0] jump_addr;

  logic        a_pc_load, a_pc_stall, a_if_id_stall, a_if_id_flush;
  logic        a_id_ex_stall, a_id_ex_flush, a_hold_ack;
  logic [31:0] a_pc_load_addr, a_stall_cnt;
  logic        b_pc_load, b_pc_stall, b_if_id_stall, b_if_id_flush;
  logic        b_id_ex_stall, b_id_ex_flush, b_hold_ack;
  logic [31:0] b_pc_load_addr;
  logic [3:0]  b_stall_cnt;

  logic [W-1:0] exp_q[$];
  int n_vec;
  int n_err;
  int n_pop;

  pipe_ctrl #(.FETCH_LAT(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .ex_rd_addr_i(ex_rd_addr),
    .ex_reg_wen_i(ex_reg_wen), .ex_is_load_i(ex_is_load),
    .jump_en_i(jump_en), .jump_addr_i(jump_addr), .hold_req_i(hold_req),
    .pc_load_o(a_pc_load), .pc_load_addr_o(a_pc_load_addr), .pc_stall_o(a_pc_stall),
    .if_id_stall_o(a_if_id_stall), .if_id_flush_o(a_if_id_flush),
    .id_ex_stall_o(a_id_ex_stall), .id_ex_flush_o(a_id_ex_flush),
    .hold_ack_o(a_hold_ack), .stall_cnt_o(a_stall_cnt)
  );

  pipe_ctrl #(.FETCH_LAT(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .ex_rd_addr_i(ex_rd_addr),
    .ex_reg_wen_i(ex_reg_wen), .ex_is_load_i(ex_is_load),
    .jump_en_i(jump_en), .jump_addr_i(jump_addr), .hold_req_i(hold_req),
    .pc_load_o(b_pc_load), .pc_load_addr_o(b_pc_load_addr), .pc_stall_o(b_pc_stall),
    .if_id_stall_o(b_if_id_stall), .if_id_flush_o(b_if_id_flush),
    .id_ex_stall_o(b_id_ex_stall), .id_ex_flush_o(b_id_ex_flush),
    .hold_ack_o(b_hold_ack), .stall_cnt_o(b_stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running exp finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wen, input logic ld, input logic jmp,
                       input logic [31:0] ja, input logic hold);
    rs1_addr   = rs1;
    rs2_addr   = rs2;
    ex_rd_addr = rd;
    ex_reg_wen = wen;
    ex_is_load = ld;
    jump_en    = jmp;
    jump_addr  = ja;
    hold_req   = hold;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  // One clock cycle: apply inputs after the edge and queue the expectation.
  task automatic vec(input bit sel,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic wen, input logic ld, input logic jmp,
                     input logic [31:0] ja, input logic hold,
                     input logic [6:0] ctl, input logic [31:0] cnt);
    logic [31:0] addr;
    @(posedge clk);
    #1;
    drive(rs1, rs2, rd, wen, ld, jmp, ja, hold);
    addr = ctl[6] ? ja : 32'd0;
    exp_q.push_back({sel, ctl, addr, cnt});
  endtask

  // Reset with a load-use pattern on the inputs: the combinational outputs
  // still follow RUN, the registered ones stay cleared.
  task automatic reset_dut(input bit sel);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle();
    vec(sel, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 7'b0110010, 32'd0);
    @(negedge clk);
    #1;
    idle();
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    logic [6:0]   got_ctl;
    logic [31:0]  got_addr, got_cnt;
    n_pop = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[71]) begin
          got_ctl  = {b_pc_load, b_pc_stall, b_if_id_stall, b_if_id_flush,
                      b_id_ex_stall, b_id_ex_flush, b_hold_ack};
          got_addr = b_pc_load_addr;
          got_cnt  = {28'd0, b_stall_cnt};
        end else begin
          got_ctl  = {a_pc_load, a_pc_stall, a_if_id_stall, a_if_id_flush,
                      a_id_ex_stall, a_id_ex_flush, a_hold_ack};
          got_addr = a_pc_load_addr;
          got_cnt  = a_stall_cnt;
        end
        n_vec++;
        if ({got_ctl, got_addr, got_cnt} !== e[70:0]) begin
          n_err++;
          $display("FAIL vec%0d dut_%s: ctl got=%b exp=%b addr got=%h exp=%h cnt got=%0d exp=%0d",
                   n_pop, e[71] ? "b" : "a", got_ctl, e[70:64], got_addr, e[63:32],
                   got_cnt, e[31:0]);
        end
        n_pop++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    #12;
    rst_n = 1'b1;

    // ---- dut_a: FETCH_LAT=1 ----
    reset_dut(1'b0);
    // load-use on rs1, then bubble, x0 never hazards, rs2 match, non-load, no wen
    vec(0, 5'd5, 5'd0, 5'd5, 1, 1, 0, 32'd0, 0, 7'b0110010, 32'd0);
    vec(0, 5'd5, 5'd0, 5'd0, 0, 0, 0, 32'd0, 0, 7'b0000000, 32'd1);
    vec(0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 32'd0, 0, 7'b0000000, 32'd1);
    vec(0, 5'd3, 5'd7, 5'd7, 1, 1, 0, 32'd0, 0, 7'b0110010, 32'd1);
    vec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 0, 7'b0000000, 32'd2);
    vec(0, 5'd7, 5'd0, 5'd7, 1, 0, 0, 32'd0, 0, 7'b0000000, 32'd2);
    vec(0, 5'd7, 5'd0, 5'd7, 0, 1, 0, 32'd0, 0, 7'b0000000, 32'd2);
    // branch beats a simultaneous load-use; FLUSH suppresses load-use
    vec(0, 5'd5, 5'd0, 5'd5, 1, 1, 1, 32'h40, 0, 7'b1001010, 32'd2);
    vec(0, 5'd5, 5'd0, 5'd5, 1, 1, 0, 32'h40, 0, 7'b0001000, 32'd2);
    vec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h40, 0, 7'b0000000, 32'd2);
    // hold for 4 cycles; jump ignored while frozen
    vec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 1, 7'b0110100, 32'd2);
    vec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 1, 7'b0110101, 32'd3);
    vec(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 32'h80, 1, 7'b0110101, 32'd4);
    vec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 1, 7'b0110101, 32'd5);
    vec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 0, 7'b0110101, 32'd6);
    vec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 0, 7'b0000000, 32'd7);
    // simultaneous jump + hold: redirect, FLUSH, then hold granted
    vec(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 32'h100, 1, 7'b1001010, 32'd7);
    vec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h100, 1, 7'b0001000, 32'd7);
    vec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 1, 7'b0110100, 32'd7);
    vec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 1, 7'b0110101, 32'd8);
    vec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 0, 7'b0110101, 32'd9);
    vec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 0, 7'b0000000, 32'd10);

    // ---- dut_b: FETCH_LAT=3, CNT_W=4 ----
    reset_dut(1'b1);
    vec(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 32'h80, 0, 7'b1001010, 32'd0);
    vec(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 0, 7'b0001000, 32'd0);
    // jump inside FLUSH reloads the counter: 3 more flush cycles, hold deferred
    vec(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 32'hC0, 0, 7'b1001010, 32'd0);
    vec(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 1, 7'b0001000, 32'd0);
    vec(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 1, 7'b0001000, 32'd0);
    vec(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 1, 7'b0001000, 32'd0);
    vec(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 1, 7'b0110100, 32'd0);
    // long hold: 4-bit counter saturates at 15
    for (int i = 1; i <= 22; i++) begin
      vec(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 1, 7'b0110101, (i > 15) ? 32'd15 : 32'(i));
    end
    // asynchronous reset in the middle of HOLD
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (b_hold_ack !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst_ack: got=%b exp=0", b_hold_ack);
    end
    n_vec++;
    if (b_stall_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL async_rst_cnt: got=%0d exp=0", b_stall_cnt);
    end
    idle();
    #3;
    rst_n = 1'b1;
    vec(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'd0, 0, 7'b0000000, 32'd0);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d entries left exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
